// File: rtl/ahb_default_slave_errlog.sv
// ---------------------------------------------------------------------------
// ahb_default_slave_errlog
//
// AHB-Lite default slave for the bus matrix. Answers every NONSEQ/SEQ
// transfer that reaches it with WAIT_STATES OKAY wait cycles followed by the
// two-cycle ERROR response. IDLE/BUSY transfers get a zero-wait OKAY.
// Alongside the response it keeps an error log for the system controller:
// first faulting address/direction (first error wins), a saturating fault
// count and a level interrupt.
//
// Parameters
//   ADDR_WIDTH  : width of HADDR / ERR_ADDR
//   WAIT_STATES : OKAY wait cycles ahead of the ERROR pair (0..15)
//   CNT_WIDTH   : width of the saturating counter ERR_CNT
//
// Ports
//   HCLK, HRESETn         : clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HREADY        : AHB-Lite address phase inputs
//   HREADYOUT, HRESP      : slave response (HRESP 00 OKAY, 01 ERROR)
//   ERR_CLR               : single-cycle clear of the log
//   ERR_VALID, ERR_ADDR,
//   ERR_WRITE, ERR_CNT    : error log contents
//   ERR_OVR               : (AHB_DSLV_OVERRUN_EN only) fault seen while the
//                           log was already full
//   IRQ                   : level interrupt
//
// Build option
//   AHB_DSLV_OVERRUN_EN   : define to add the ERR_OVR overrun flag; IRQ then
//                           also fires on overrun.
// ---------------------------------------------------------------------------
module ahb_default_slave_errlog #(
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  input  logic                  ERR_CLR,
  output logic                  ERR_VALID,
  output logic [ADDR_WIDTH-1:0] ERR_ADDR,
  output logic                  ERR_WRITE,
  output logic [CNT_WIDTH-1:0]  ERR_CNT,
`ifdef AHB_DSLV_OVERRUN_EN
  output logic                  ERR_OVR,
`endif
  output logic                  IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  localparam bit         HAS_WAIT = (WAIT_STATES > 0);
  // Counter preload; unused (and kept legal) when there are no wait states.
  localparam logic [3:0] WS_LOAD  = 4'(HAS_WAIT ? WAIT_STATES - 1 : 0);

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_wcnt, w_wcnt_nxt;
  logic                  w_accept;
  logic                  w_unused;

  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [CNT_WIDTH-1:0]  r_cnt;

  // HTRANS[0] only separates NONSEQ/SEQ and IDLE/BUSY, both treated alike.
  assign w_unused = HTRANS[0];

  // A real transfer: selected, bus ready, NONSEQ or SEQ.
  assign w_accept = HSEL & HREADY & HTRANS[1];

  // -------------------------------------------------------------------------
  // Response FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      S_IDLE, S_ERR2: begin
        // ERR2 is the last data-phase cycle, so it may overlap the next
        // address phase: a back-to-back fault skips IDLE altogether.
        if (w_accept) begin
          if (HAS_WAIT) begin
            w_state_nxt = S_WAIT;
            w_wcnt_nxt  = WS_LOAD;
          end else begin
            w_state_nxt = S_ERR1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_wcnt == 4'd0) w_state_nxt = S_ERR1;
        else                w_wcnt_nxt  = r_wcnt - 4'd1;
      end
      S_ERR1:  w_state_nxt = S_ERR2;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are a pure decode of the state register, so they are glitch-free
  // and follow the asynchronous reset immediately.
  assign HREADYOUT = (r_state == S_IDLE) || (r_state == S_ERR2);
  assign HRESP     = {1'b0, (r_state == S_ERR1) || (r_state == S_ERR2)};

  // -------------------------------------------------------------------------
  // Error log, captured in the address phase
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      // A clear coincident with a fault is superseded by the new capture.
      if (!r_valid || ERR_CLR) begin
        r_valid <= 1'b1;
        r_addr  <= HADDR;
        r_write <= HWRITE;
      end
      if (ERR_CLR)     r_cnt <= CNT_WIDTH'(1);
      else if (!(&r_cnt)) r_cnt <= r_cnt + CNT_WIDTH'(1);
    end else if (ERR_CLR) begin
      // Address/direction are deliberately kept for post-mortem reads.
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end
  end

  assign ERR_VALID = r_valid;
  assign ERR_ADDR  = r_addr;
  assign ERR_WRITE = r_write;
  assign ERR_CNT   = r_cnt;

`ifdef AHB_DSLV_OVERRUN_EN
  logic r_ovr;

  // Flags faults lost to the first-error-wins policy.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                 r_ovr <= 1'b0;
    else if (ERR_CLR)             r_ovr <= 1'b0;
    else if (w_accept && r_valid) r_ovr <= 1'b1;
  end

  assign ERR_OVR = r_ovr;
  assign IRQ     = r_valid | r_ovr;
`else
  assign IRQ     = r_valid;
`endif

endmodule

// File: tb/tb_ahb_default_slave_errlog.sv
// ---------------------------------------------------------------------------
// tb_ahb_default_slave_errlog
//
// Directed bench for ahb_default_slave_errlog. Two instances share the bus
// inputs but have separate HSEL:
//   u_dut0 : WAIT_STATES=0, CNT_WIDTH=2 (response, back-to-back, saturation,
//            clear, async reset)
//   u_dut3 : WAIT_STATES=3, CNT_WIDTH=8 (wait states, write capture,
//            first-error-wins)
// Inputs change 1 time unit after the rising edge; outputs are read there.
// ---------------------------------------------------------------------------
module tb_ahb_default_slave_errlog;

  logic        HCLK;
  logic        HRESETn;
  logic        hsel0, hsel3;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        ERR_CLR;

  logic        hro0, hro3;
  logic [1:0]  hresp0, hresp3;
  logic        vld0, vld3;
  logic [31:0] eaddr0, eaddr3;
  logic        ewr0, ewr3;
  logic [1:0]  ecnt0;
  logic [7:0]  ecnt3;
  logic        irq0, irq3;
`ifdef AHB_DSLV_OVERRUN_EN
  logic        ovr0, ovr3;
`endif

  int n_chk;
  int n_err;

  ahb_default_slave_errlog #(.ADDR_WIDTH(32), .WAIT_STATES(0), .CNT_WIDTH(2)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY),
    .HREADYOUT(hro0), .HRESP(hresp0), .ERR_CLR(ERR_CLR),
    .ERR_VALID(vld0), .ERR_ADDR(eaddr0), .ERR_WRITE(ewr0), .ERR_CNT(ecnt0),
`ifdef AHB_DSLV_OVERRUN_EN
    .ERR_OVR(ovr0),
`endif
    .IRQ(irq0)
  );

  ahb_default_slave_errlog #(.ADDR_WIDTH(32), .WAIT_STATES(3), .CNT_WIDTH(8)) u_dut3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY),
    .HREADYOUT(hro3), .HRESP(hresp3), .ERR_CLR(ERR_CLR),
    .ERR_VALID(vld3), .ERR_ADDR(eaddr3), .ERR_WRITE(ewr3), .ERR_CNT(ecnt3),
`ifdef AHB_DSLV_OVERRUN_EN
    .ERR_OVR(ovr3),
`endif
    .IRQ(irq3)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    hsel0   = 1'b0;
    hsel3   = 1'b0;
    HTRANS  = 2'b00;
    HWRITE  = 1'b0;
    ERR_CLR = 1'b0;
  endtask

  // Address phase of a NONSEQ transfer to dut0.
  task automatic nonseq0(input logic [31:0] a, input logic wr);
    hsel0  = 1'b1;
    HADDR  = a;
    HWRITE = wr;
    HTRANS = 2'b10;
  endtask

  // One complete faulting transfer on dut0, ending back in IDLE.
  task automatic fault0(input logic [31:0] a);
    nonseq0(a, 1'b0);
    tick();
    bus_idle();
    tick();
    tick();
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    HRESETn = 1'b0;
    HADDR   = '0;
    HREADY  = 1'b1;
    bus_idle();

    #12;
    chk("rst_hready0", {63'd0, hro0}, 64'd1);
    chk("rst_hresp0",  {62'd0, hresp0}, 64'd0);
    chk("rst_valid0",  {63'd0, vld0}, 64'd0);
    chk("rst_cnt0",    {62'd0, ecnt0}, 64'd0);
    chk("rst_addr0",   {32'd0, eaddr0}, 64'd0);
    chk("rst_irq3",    {63'd0, irq3}, 64'd0);
    HRESETn = 1'b1;
    tick();

    // 1: zero-wait fault, read
    nonseq0(32'h4000_0010, 1'b0);
    tick();
    bus_idle();
    chk("t1_err1", {62'd0, hro0, hresp0[0]}, 64'b00_1 & 64'h3 | 64'h1);
    chk("t1_hresp_e1", {62'd0, hresp0}, 64'd1);
    chk("t1_addr",  {32'd0, eaddr0}, 64'h4000_0010);
    chk("t1_write", {63'd0, ewr0}, 64'd0);
    chk("t1_cnt",   {62'd0, ecnt0}, 64'd1);
    chk("t1_irq",   {63'd0, irq0}, 64'd1);
    tick();
    chk("t1_err2_rdy", {63'd0, hro0}, 64'd1);
    chk("t1_err2_rsp", {62'd0, hresp0}, 64'd1);
    tick();
    chk("t1_idle_rdy", {63'd0, hro0}, 64'd1);
    chk("t1_idle_rsp", {62'd0, hresp0}, 64'd0);

    // 2: three wait states, write, on dut3
    hsel3  = 1'b1;
    HADDR  = 32'h5000_0020;
    HWRITE = 1'b1;
    HTRANS = 2'b10;
    tick();
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_wait%0d", i), {61'd0, hro3, hresp3}, {61'd0, 1'b0, 2'b00});
      tick();
    end
    chk("t2_err1", {61'd0, hro3, hresp3}, {61'd0, 1'b0, 2'b01});
    tick();
    chk("t2_err2", {61'd0, hro3, hresp3}, {61'd0, 1'b1, 2'b01});
    tick();
    chk("t2_idle", {61'd0, hro3, hresp3}, {61'd0, 1'b1, 2'b00});
    chk("t2_write", {63'd0, ewr3}, 64'd1);
    chk("t2_addr",  {32'd0, eaddr3}, 64'h5000_0020);

    // second fault on dut3 must not overwrite the log
    hsel3  = 1'b1;
    HADDR  = 32'h5000_0044;
    HWRITE = 1'b0;
    HTRANS = 2'b11;
    tick();
    bus_idle();
    for (int i = 0; i < 6; i++) tick();
    chk("t2_first_wins", {32'd0, eaddr3}, 64'h5000_0020);
    chk("t2_write_hold", {63'd0, ewr3}, 64'd1);
    chk("t2_cnt2", {56'd0, ecnt3}, 64'd2);
`ifdef AHB_DSLV_OVERRUN_EN
    chk("t2_ovr", {63'd0, ovr3}, 64'd1);
`endif

    // 3: IDLE and BUSY transfers are zero-wait OKAY and not counted
    hsel0  = 1'b1;
    HADDR  = 32'h0000_0abc;
    HTRANS = 2'b00;
    tick();
    chk("t3_idle", {61'd0, hro0, hresp0}, {61'd0, 1'b1, 2'b00});
    HTRANS = 2'b01;
    tick();
    chk("t3_busy", {61'd0, hro0, hresp0}, {61'd0, 1'b1, 2'b00});
    bus_idle();
    tick();
    chk("t3_cnt", {62'd0, ecnt0}, 64'd1);

    // clear alone: valid/count drop, address/direction hold
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    chk("clr_valid", {63'd0, vld0}, 64'd0);
    chk("clr_cnt",   {62'd0, ecnt0}, 64'd0);
    chk("clr_irq",   {63'd0, irq0}, 64'd0);
    chk("clr_addr_hold", {32'd0, eaddr0}, 64'h4000_0010);

    // 4: back-to-back faults, second address phase during ERR2
    nonseq0(32'h0000_0100, 1'b0);
    tick();
    bus_idle();
    chk("t4_err1a", {61'd0, hro0, hresp0}, {61'd0, 1'b0, 2'b01});
    tick();
    chk("t4_err2a", {61'd0, hro0, hresp0}, {61'd0, 1'b1, 2'b01});
    nonseq0(32'h0000_0200, 1'b1);
    tick();
    bus_idle();
    chk("t4_err1b", {61'd0, hro0, hresp0}, {61'd0, 1'b0, 2'b01});
    tick();
    chk("t4_err2b", {61'd0, hro0, hresp0}, {61'd0, 1'b1, 2'b01});
    tick();
    chk("t4_idle", {61'd0, hro0, hresp0}, {61'd0, 1'b1, 2'b00});
    chk("t4_addr", {32'd0, eaddr0}, 64'h0000_0100);
    chk("t4_write", {63'd0, ewr0}, 64'd0);
    chk("t4_cnt", {62'd0, ecnt0}, 64'd2);
`ifdef AHB_DSLV_OVERRUN_EN
    chk("t4_ovr", {63'd0, ovr0}, 64'd1);
`endif

    // 5: saturation of the 2-bit counter (five faults total)
    fault0(32'h0000_0104);
    chk("t5_cnt3", {62'd0, ecnt0}, 64'd3);
    fault0(32'h0000_0108);
    fault0(32'h0000_010c);
    chk("t5_sat", {62'd0, ecnt0}, 64'd3);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    chk("t5_clr_valid", {63'd0, vld0}, 64'd0);
    chk("t5_clr_cnt", {62'd0, ecnt0}, 64'd0);
    chk("t5_clr_irq", {63'd0, irq0}, 64'd0);
`ifdef AHB_DSLV_OVERRUN_EN
    chk("t5_clr_ovr", {63'd0, ovr0}, 64'd0);
`endif
    // clear coincident with a fault: the capture wins
    nonseq0(32'h0000_0300, 1'b1);
    ERR_CLR = 1'b1;
    tick();
    bus_idle();
    chk("t5_co_cnt", {62'd0, ecnt0}, 64'd1);
    chk("t5_co_addr", {32'd0, eaddr0}, 64'h0000_0300);
    chk("t5_co_valid", {63'd0, vld0}, 64'd1);
    chk("t5_co_write", {63'd0, ewr0}, 64'd1);
    chk("t5_co_resp", {61'd0, hro0, hresp0}, {61'd0, 1'b0, 2'b01});
    tick();
    tick();

    // 6: asynchronous reset during ERR1
    nonseq0(32'h0000_0400, 1'b0);
    tick();
    bus_idle();
    chk("t6_err1", {61'd0, hro0, hresp0}, {61'd0, 1'b0, 2'b01});
    #2;
    HRESETn = 1'b0;
    #1;
    chk("t6_rst_resp", {61'd0, hro0, hresp0}, {61'd0, 1'b1, 2'b00});
    chk("t6_rst_valid", {63'd0, vld0}, 64'd0);
    chk("t6_rst_cnt", {62'd0, ecnt0}, 64'd0);
    chk("t6_rst_addr", {32'd0, eaddr0}, 64'd0);
    chk("t6_rst_irq", {63'd0, irq0}, 64'd0);
    #1;
    HRESETn = 1'b1;
    tick();
    chk("t6_after", {61'd0, hro0, hresp0}, {61'd0, 1'b1, 2'b00});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_default_slave_errlog.md
Name: ahb_default_slave_errlog

Overview:
Parametrised AHB-Lite default slave for the bus matrix. It drives HREADYOUT/HRESP when no real slave is decoded. Every non-IDLE/BUSY transfer gets a two-cycle ERROR response, preceded by a configurable number of wait states. It also records the first faulting address and direction, keeps a saturating error count, and raises a level interrupt to the system controller.

Parameters:
ADDR_WIDTH, 32, width of HADDR and ERR_ADDR
WAIT_STATES, 0, extra HREADYOUT-low OKAY cycles before the ERROR pair (0..15)
CNT_WIDTH, 8, width of the saturating error counter ERR_CNT

Ports:
HCLK  input  1  AHB clock
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  default-slave select
HADDR  input  ADDR_WIDTH  transfer address
HTRANS  input  2  transfer type
HWRITE  input  1  transfer direction
HREADY  input  1  bus ready (transfer done)
HREADYOUT  output  1  slave ready
HRESP  output  2  response, 00 OKAY, 01 ERROR
ERR_CLR  input  1  single-cycle clear of the error log
ERR_VALID  output  1  error log holds a captured fault
ERR_ADDR  output  ADDR_WIDTH  address of the first captured fault
ERR_WRITE  output  1  HWRITE of the first captured fault
ERR_CNT  output  CNT_WIDTH  saturating count of faulting transfers
IRQ  output  1  interrupt, equal to ERR_VALID

Behaviour:
- Reset: HRESETn (asynchronous, active-low) with clock HCLK. All registers clear: HREADYOUT=1, HRESP=00, state IDLE, ERR_VALID=0, ERR_ADDR=0, ERR_WRITE=0, ERR_CNT=0, IRQ=0.
- accept = HSEL & HREADY & HTRANS[1]. Only NONSEQ and SEQ transfers count. IDLE and BUSY transfers get a zero-wait OKAY.
- Outputs are registered and decoded from state:
  - IDLE: HREADYOUT=1, HRESP=00
  - WAIT: HREADYOUT=0, HRESP=00
  - ERR1: HREADYOUT=0, HRESP=01
  - ERR2: HREADYOUT=1, HRESP=01
- IDLE: on accept, go to WAIT with wcnt=WAIT_STATES-1 if WAIT_STATES>0, otherwise go to ERR1.
- WAIT: if wcnt==0 go to ERR1, else decrement wcnt. HSEL/HTRANS are ignored in this state.
- ERR1: always go to ERR2.
- ERR2: on accept (back-to-back transfer), go to WAIT/ERR1 exactly as from IDLE. Otherwise go to IDLE.
- Latency: the ERROR response completes WAIT_STATES+2 cycles after the address phase. Back-to-back faulting transfers have no IDLE cycle between them.
- Log capture happens in the accept cycle (address phase). If ERR_VALID==0, load ERR_ADDR=HADDR, ERR_WRITE=HWRITE and set ERR_VALID=1. Policy is first-error-wins: later faults never overwrite the log.
- ERR_CNT increments on every accept and saturates at all-ones with no wrap.
- ERR_CLR alone: ERR_VALID=0 and ERR_CNT=0. ERR_ADDR and ERR_WRITE hold their values.
- ERR_CLR in the same cycle as accept: the new capture wins, giving ERR_VALID=1, ERR_CNT=1, ERR_ADDR=HADDR.
- ERR_CLR does not affect the response FSM.
- Reset mid-response: the FSM returns to IDLE immediately and the outputs take their reset values. The log is lost.

Optional Feature:
AHB_DSLV_OVERRUN_EN.
- Defined: adds output ERR_OVR (1 bit, reset 0). It sets on accept while ERR_VALID==1 and accept is not coincident with ERR_CLR, and clears on ERR_CLR. IRQ = ERR_VALID | ERR_OVR.
- Undefined: no ERR_OVR port. IRQ = ERR_VALID.

Test Plan:
1. WAIT_STATES=0: NONSEQ read to HADDR=0x4000_0010 with HSEL=1 -> next cycle HREADYOUT=0/HRESP=01, following cycle HREADYOUT=1/HRESP=01, then 1/00. ERR_ADDR=0x4000_0010, ERR_WRITE=0, ERR_CNT=1, IRQ=1.
2. WAIT_STATES=3: NONSEQ write -> 3 cycles of HREADYOUT=0/HRESP=00, then ERR1, then ERR2. ERR_WRITE=1.
3. HTRANS=IDLE (00) and BUSY (01) with HSEL=1 -> HREADYOUT stays 1, HRESP=00, ERR_CNT unchanged.
4. Two back-to-back NONSEQs at 0x100 and 0x200 (second address phase during ERR2) -> ERR1/ERR2/ERR1/ERR2 with no IDLE cycle. ERR_ADDR=0x100, ERR_CNT=2.
5. CNT_WIDTH=2: five faults -> ERR_CNT=3 (saturated). ERR_CLR pulse -> ERR_VALID=0, ERR_CNT=0, IRQ=0. ERR_CLR coincident with a fault at 0x300 -> ERR_CNT=1, ERR_ADDR=0x300.
6. HRESETn asserted during ERR1 -> HREADYOUT=1, HRESP=00 and the log clears in the same cycle, without waiting for a clock edge.
